// File: rtl/iob_bus_merge.sv
// Two-master to one-slave native-bus merger with a registered outgoing request.
// Define IOB_BUS_MERGE_RR_EN for round-robin arbitration; the default is fixed priority (m1 wins).
module iob_bus_merge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8,
  localparam int RESP_W = DATA_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  m0_req,
  output logic [RESP_W-1:0] m0_resp,
  input  logic [REQ_W-1:0]  m1_req,
  output logic [RESP_W-1:0] m1_resp,
  output logic [REQ_W-1:0]  s_req,
  input  logic [RESP_W-1:0] s_resp
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [REQ_W-1:0]   s_req_q, s_req_d;
  logic               grant_q, grant_d;
  logic               m0_v, m1_v, sel;
  logic               s_ready, busy;

  assign m0_v    = m0_req[REQ_W-1];
  assign m1_v    = m1_req[REQ_W-1];
  assign s_ready = s_resp[0];
  assign busy    = (state_q == BUSY);

`ifdef IOB_BUS_MERGE_RR_EN
  logic last_grant_q, last_grant_d;

  // On contention the master that was not served last wins.
  always_comb begin
    sel = m1_v;
    if (m0_v && m1_v) sel = ~last_grant_q;
  end
`else
  always_comb begin
    sel = m1_v;
  end
`endif

  always_comb begin
    state_d = state_q;
    s_req_d = s_req_q;
    grant_d = grant_q;
`ifdef IOB_BUS_MERGE_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_v || m1_v) begin
          state_d = BUSY;
          grant_d = sel;
          s_req_d = {1'b1, sel ? m1_req[REQ_W-2:0] : m0_req[REQ_W-2:0]};
        end
      end
      BUSY: begin
        // Master valids are ignored here; the committed request runs to completion.
        if (s_ready) begin
          state_d            = IDLE;
          s_req_d[REQ_W-1]   = 1'b0;
`ifdef IOB_BUS_MERGE_RR_EN
          last_grant_d       = grant_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_req_q <= '0;
      grant_q <= 1'b0;
`ifdef IOB_BUS_MERGE_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      s_req_q <= s_req_d;
      grant_q <= grant_d;
`ifdef IOB_BUS_MERGE_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign s_req   = s_req_q;
  assign m0_resp = {s_resp[RESP_W-1:1], s_ready & busy & ~grant_q};
  assign m1_resp = {s_resp[RESP_W-1:1], s_ready & busy &  grant_q};

endmodule

// File: doc/iob_bus_merge.md
# iob_bus_merge

Two-master to one-slave native-bus merger that sits directly downstream of the PicoRV32 wrapper. It takes the CPU's instruction bus and data bus and serialises them onto a single memory port (boot SRAM, or external-memory cache front end). The outgoing request is registered, which breaks the combinational valid/ready loop created by the CPU's `valid & ~ready` masking. Transactions are arbitrated one at a time, and each runs to completion.

## Interface

Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. Must be a multiple of 8.
- Derived widths: `REQ_W = 1+ADDR_W+DATA_W+DATA_W/8` (69 at defaults) and `RESP_W = DATA_W+1` (33).
- Request layout, MSB first: `{valid, addr[ADDR_W-1:0], wdata[DATA_W-1:0], wstrb[DATA_W/8-1:0]}`.
- Response layout, MSB first: `{rdata[DATA_W-1:0], ready}`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `m0_req`, input, REQ_W: master 0 request (instruction bus).
- `m0_resp`, output, RESP_W: master 0 response.
- `m1_req`, input, REQ_W: master 1 request (data bus).
- `m1_resp`, output, RESP_W: master 1 response.
- `s_req`, output, REQ_W: merged request to the slave.
- `s_resp`, input, RESP_W: slave response.

## Operation

State machine: `IDLE`, `BUSY`.

IDLE:
- If any master has `valid`=1, select one according to the arbitration rule below.
- Register that master's address, wdata and wstrb into `s_req`.
- Set the registered `s_req.valid`=1.
- Latch `grant` (0 or 1) and go to BUSY.
- If no master is valid, remain in IDLE.

BUSY:
- `s_req` is held constant.
- Master `valid` inputs are ignored. A committed transaction always completes, even if the granted master drops valid.
- When `s_resp.ready`=1:
  - Clear `s_req.valid` at the next edge.
  - Go to IDLE.
  - Update `last_grant` to the current `grant`.

Response routing (combinational):
- `m0_resp.rdata` and `m1_resp.rdata` both equal `s_resp.rdata` at all times.
- `mX_resp.ready = s_resp.ready & (state==BUSY) & (grant==X)`.
- `s_resp.ready` while in IDLE is ignored and never forwarded to a master.

Arbitration:
- Selected by the macro described under Configuration.
- Only one grant is issued per IDLE cycle.
- A losing master keeps its valid asserted and is served on a later IDLE cycle.

Write/read:
- `wstrb`≠0 is a write and `wstrb`=0 is a read. The block does not interpret this; it passes the field through unchanged.

## Timing

Reset values (applied asynchronously on `rst`):
- `state`=IDLE.
- `s_req` = all zeros, so `valid`=0.
- `grant`=0.
- `last_grant`=1.
- `m0_resp.ready` = `m1_resp.ready` = 0.

Latency and throughput:
- A master request sampled valid at edge N produces `s_req.valid`=1 from N (visible during cycle N+1).
- Slave `ready` in cycle M appears at the granted master's `ready` in the same cycle M, so there is zero response latency.
- The earliest next `s_req.valid` follows the edge after M+1.
- Minimum cost is 2 cycles per transaction plus slave wait states.

Slave handshake rules:
- `s_req.valid` stays high until the slave returns ready.
- The slave must not assert ready unless `valid`=1.
- Multi-cycle slave latency is unbounded.

Reset during BUSY:
- Immediately drop `s_req.valid`.
- The in-flight response is discarded.
- The master re-issues its request after reset.

Simultaneous events:
- Both masters valid in IDLE: exactly one is granted. The other sees `ready`=0 and is granted on the next IDLE cycle.

## Configuration

- `IOB_BUS_MERGE_RR_EN` defined: round-robin arbitration. On contention, grant the master ≠ `last_grant`. `last_grant` resets to 1, so m0 (ibus) wins the first contention.
- `IOB_BUS_MERGE_RR_EN` undefined: fixed priority, m1 (dbus) always wins on contention. The `last_grant` register is not implemented.

## Test plan

- **Single read:** m0 requests addr `0x100`, wstrb=0; slave answers `rdata=0xDEADBEEF` with 2 wait states.
  - `s_req.valid` appears 1 cycle after the request with addr `0x100`.
  - `m0_resp.ready` pulses exactly 1 cycle with `0xDEADBEEF`.
  - `m1_resp.ready` stays 0.
- **Single write:** m1 requests addr `0x2000`, wdata `0x12345678`, wstrb `4'b0011`.
  - `s_req` carries identical fields.
  - `m1_resp.ready` pulses once.
  - The FSM returns to IDLE one cycle later.
- **Contention, RR_EN defined:** both masters hold valid for 4 transactions, slave has zero wait.
  - Grant order is m0, m1, m0, m1.
  - Each `ready` goes only to its owner.
- **Contention, RR_EN undefined:** same stimulus as above.
  - m1 is served for all 4 transactions.
  - m0 is granted only after m1 drops valid.
- **Reset mid-transaction:** assert `rst` while BUSY and the slave is waiting.
  - `s_req.valid`=0 immediately, with no clock edge needed.
  - Both `ready` outputs are 0.
  - After release, the FSM is in IDLE and a new m0 request is forwarded normally.
- **Spurious slave ready / dropped valid:**
  - A slave ready pulse while IDLE produces no master ready.
  - If the granted master drops valid in BUSY, the transaction still completes and `ready` is routed to that master.
